// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder; one full-adder cell (two half adders + OR)
// and a registered carry, with valid/ready handshakes on operands and result.
module halfadder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0] r_count;
  logic r_carry, r_cout;
  logic w_p, w_g, w_s, w_g2, w_cy;
  logic [WIDTH:0] w_sh;
  halfadder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_p), .o_c(w_g));
  halfadder u_ha1 (.i_a(w_p), .i_b(r_carry), .o_s(w_s), .o_c(w_g2));
  assign w_cy = w_g | w_g2;
  // new bit enters at the MSB; concatenation keeps WIDTH=1 legal
  assign w_sh = {w_s, r_sum};
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && in_valid) ? RUN :
             (r_state == RUN && r_count == LAST) ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= c_in;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_cy;
        r_sum   <= w_sh[WIDTH:1];
        r_count <= r_count + 1'b1;
        if (r_count == LAST) r_cout <= w_cy;
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == RUN;
  assign out_valid = r_state == DONE;
  assign sum       = r_sum;
  assign c_out     = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH 8, 4 and 1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       iv [3];
  logic       ordy [3];
  logic [7:0] ta [3];
  logic [7:0] tb [3];
  logic       tc [3];
  logic       ir [3];
  logic       ov [3];
  logic       tco [3];
  logic       tbz [3];
  logic [7:0] ts [3];
  logic [3:0] s4;
  logic [0:0] s1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tb[0]),
    .c_in(tc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(ts[0]), .c_out(tco[0]),
    .busy(tbz[0]));
  serial_adder #(.WIDTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1][3:0]),
    .b(tb[1][3:0]), .c_in(tc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s4),
    .c_out(tco[1]), .busy(tbz[1]));
  serial_adder #(.WIDTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2][0:0]),
    .b(tb[2][0:0]), .c_in(tc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s1),
    .c_out(tco[2]), .busy(tbz[2]));
  assign ts[1] = {4'b0, s4};
  assign ts[2] = {7'b0, s1};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input int k, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    ta[k] = av;
    tb[k] = bv;
    tc[k] = cv;
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    ta[k] = ~av;
    tb[k] = ~bv;
    tc[k] = ~cv;
  endtask
  task automatic op(input int k, input int w, input logic [7:0] av, input logic [7:0] bv,
                    input logic cv, input logic [8:0] expv, input string tag);
    int n = 0;
    chk({tag, " ready"}, 32'(ir[k]), 1);
    accept(k, av, bv, cv);
    while (!ov[k] && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " lat"}, n, w);
    chk({tag, " res"}, (32'(tco[k]) << w) | 32'(ts[k]), 32'(expv));
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    chk({tag, " idle"}, {ov[k], ir[k]}, 2'b01);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ta[k] = '0; tb[k] = '0; tc[k] = 1'b0;
    end
    #12;
    chk("rst", {ir[0], tbz[0], ov[0], tco[0], ts[0]}, 12'h800);
    rst_n = 1'b1;
    tick();
    op(0, 8, 8'h00, 8'h00, 1'b0, 9'h000, "t1");
    op(0, 8, 8'hFF, 8'h01, 1'b0, 9'h100, "t2");
    op(0, 8, 8'hA5, 8'h5A, 1'b1, 9'h100, "t3");
    op(0, 8, 8'h80, 8'h80, 1'b1, 9'h101, "ovf");
    accept(0, 8'h3C, 8'h0F, 1'b0);
    chk("t4 busy", {tbz[0], ir[0]}, 2'b10);
    for (int i = 0; i < 8 && !ov[0]; i++) tick();
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4 hold", {ov[0], ir[0], tbz[0], tco[0], ts[0]}, 12'h84B);
      tick();
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("t4 rel", {ov[0], ir[0], tco[0], ts[0]}, 11'h24B);
    tick();
    chk("t4 noacc", {ir[0], tbz[0]}, 2'b10);
    accept(0, 8'hFF, 8'h00, 1'b0);
    tick(); tick(); tick();
    chk("t5 run", {tbz[0], ts[0]}, 9'h1E0);
    rst_n = 1'b0;
    #1;
    chk("t5 rst", {ir[0], tbz[0], ov[0], tco[0], ts[0]}, 12'h800);
    tick();
    rst_n = 1'b1;
    tick();
    op(0, 8, 8'h12, 8'h34, 1'b0, 9'h046, "t5");
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          op(1, 4, 8'(x), 8'(y), c[0], 9'(x + y + c), $sformatf("w4 %0d+%0d+%0d", x, y, c));
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++)
          op(2, 1, 8'(x), 8'(y), c[0], 9'(x + y + c), $sformatf("w1 %0d+%0d+%0d", x, y, c));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
